tmds_channel_rx: RTL

TMDS_CHANNEL_RX -- requirements
Module: tmds_channel_rx

---
 rtl/tmds_channel_rx_if.sv | 27 ++
 rtl/tmds_channel_rx.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/tmds_channel_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : tmds_channel_rx_if
// Brief    : Word/decode bundle between a TMDS word source and the channel RX.
// Revision : 1.0 - initial release
// ============================================================================
interface tmds_channel_rx_if;
    logic [9:0] raw_word;
    logic [7:0] data;
    logic       c0;
    logic       c1;
    logic       de;
    logic       locked;
    logic [3:0] align_offset;
    logic       lock_lost;

    modport master (
        output raw_word,
        input  data, c0, c1, de, locked, align_offset, lock_lost
    );

    modport slave (
        input  raw_word,
        output data, c0, c1, de, locked, align_offset, lock_lost
    );
endinterface
`default_nettype wire

// File: rtl/tmds_channel_rx.sv
`default_nettype none
// ============================================================================
// Module   : tmds_channel_rx
// Brief    : TMDS channel receiver: word alignment search and 8b/10b decode.
// Revision : 1.0 - initial release
// ============================================================================
module tmds_channel_rx #(
    parameter int CTRL_RUN      = 8,
    parameter int SEARCH_WINDOW = 64,
    parameter int CTRL_TIMEOUT  = 2048
) (
    input  wire logic         clk_pixel,
    input  wire logic         reset,
    tmds_channel_rx_if.slave  bus
);

    localparam int RUN_W = $clog2(CTRL_RUN + 1);
    localparam int WIN_W = $clog2(SEARCH_WINDOW + 1);
    localparam int TO_W  = $clog2(CTRL_TIMEOUT + 1);

    localparam logic [RUN_W-1:0] C_RUN_LAST = RUN_W'(CTRL_RUN - 1);
    localparam logic [WIN_W-1:0] C_WIN_LAST = WIN_W'(SEARCH_WINDOW - 1);
    localparam logic [TO_W-1:0]  C_TO_LAST  = TO_W'(CTRL_TIMEOUT - 1);
    localparam logic [RUN_W-1:0] C_RUN_MAX  = '1;
    localparam logic [WIN_W-1:0] C_WIN_MAX  = '1;
    localparam logic [TO_W-1:0]  C_TO_MAX   = '1;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_SLIP   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t           state_q,     state_d;
    logic [3:0]       offset_q,    offset_d;
    logic [9:0]       prev_word_q;
    logic [RUN_W-1:0] run_cnt_q,   run_cnt_d;
    logic [WIN_W-1:0] win_cnt_q,   win_cnt_d;
    logic [TO_W-1:0]  to_cnt_q,    to_cnt_d;
    logic [7:0]       data_q,      data_d;
    logic             c0_q,        c0_d;
    logic             c1_q,        c1_d;
    logic             de_q,        de_d;
    logic             locked_q,    locked_d;
    logic             lock_lost_q, lock_lost_d;

    logic [19:0]      w_pair;
    logic [9:0]       w_window;
    logic             w_is_token;
    logic [1:0]       w_token_c;
    logic [7:0]       w_q;
    logic [7:0]       w_decoded;
    logic [3:0]       w_next_offset;

    // Offset 0 selects the previous word; higher offsets pull in bits of the current word.
    assign w_pair        = {bus.raw_word, prev_word_q};
    assign w_window      = 10'(w_pair >> offset_q);
    assign w_next_offset = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;

    always_comb begin
        w_is_token = 1'b1;
        w_token_c  = 2'b00;
        case (w_window)
            10'h354: w_token_c = 2'b00;
            10'h0AB: w_token_c = 2'b01;
            10'h154: w_token_c = 2'b10;
            10'h2AB: w_token_c = 2'b11;
            default: w_is_token = 1'b0;
        endcase
    end

    always_comb begin
        w_q          = w_window[9] ? ~w_window[7:0] : w_window[7:0];
        w_decoded    = 8'h00;
        w_decoded[0] = w_q[0];
        for (int i = 1; i < 8; i++) begin
            w_decoded[i] = w_window[8] ? (w_q[i] ^ w_q[i-1]) : ~(w_q[i] ^ w_q[i-1]);
        end
    end

    always_comb begin
        state_d     = state_q;
        offset_d    = offset_q;
        run_cnt_d   = run_cnt_q;
        win_cnt_d   = win_cnt_q;
        to_cnt_d    = to_cnt_q;
        lock_lost_d = 1'b0;
        case (state_q)
            ST_SEARCH: begin
                // A completed token run takes priority over an expiring window.
                if (w_is_token && (run_cnt_q >= C_RUN_LAST)) begin
                    state_d   = ST_LOCKED;
                    run_cnt_d = '0;
                    win_cnt_d = '0;
                    to_cnt_d  = '0;
                end else if (win_cnt_q >= C_WIN_LAST) begin
                    state_d   = ST_SLIP;
                    run_cnt_d = '0;
                    win_cnt_d = '0;
                end else begin
                    if (w_is_token) begin
                        run_cnt_d = (run_cnt_q == C_RUN_MAX) ? run_cnt_q : run_cnt_q + 1'b1;
                    end else begin
                        run_cnt_d = '0;
                    end
                    win_cnt_d = (win_cnt_q == C_WIN_MAX) ? win_cnt_q : win_cnt_q + 1'b1;
                end
            end
            ST_SLIP: begin
                state_d   = ST_SEARCH;
                offset_d  = w_next_offset;
                run_cnt_d = '0;
                win_cnt_d = '0;
                to_cnt_d  = '0;
            end
            ST_LOCKED: begin
                if (w_is_token) begin
                    to_cnt_d = '0;
                end else if (to_cnt_q >= C_TO_LAST) begin
                    state_d     = ST_SEARCH;
                    offset_d    = w_next_offset;
                    lock_lost_d = 1'b1;
                    run_cnt_d   = '0;
                    win_cnt_d   = '0;
                    to_cnt_d    = '0;
                end else begin
                    to_cnt_d = (to_cnt_q == C_TO_MAX) ? to_cnt_q : to_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d   = ST_SEARCH;
                offset_d  = 4'd0;
                run_cnt_d = '0;
                win_cnt_d = '0;
                to_cnt_d  = '0;
            end
        endcase
    end

    // Decoded outputs are gated by the lock flag registered alongside them.
    always_comb begin
        locked_d = (state_d == ST_LOCKED);
        data_d   = 8'h00;
        c0_d     = 1'b0;
        c1_d     = 1'b0;
        de_d     = 1'b0;
        if (locked_d) begin
            if (w_is_token) begin
                c0_d = w_token_c[0];
                c1_d = w_token_c[1];
            end else begin
                de_d   = 1'b1;
                data_d = w_decoded;
            end
        end
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            state_q     <= ST_SEARCH;
            offset_q    <= 4'd0;
            prev_word_q <= 10'd0;
            run_cnt_q   <= '0;
            win_cnt_q   <= '0;
            to_cnt_q    <= '0;
            data_q      <= 8'h00;
            c0_q        <= 1'b0;
            c1_q        <= 1'b0;
            de_q        <= 1'b0;
            locked_q    <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            offset_q    <= offset_d;
            prev_word_q <= bus.raw_word;
            run_cnt_q   <= run_cnt_d;
            win_cnt_q   <= win_cnt_d;
            to_cnt_q    <= to_cnt_d;
            data_q      <= data_d;
            c0_q        <= c0_d;
            c1_q        <= c1_d;
            de_q        <= de_d;
            locked_q    <= locked_d;
            lock_lost_q <= lock_lost_d;
        end
    end

    assign bus.data         = data_q;
    assign bus.c0           = c0_q;
    assign bus.c1           = c1_q;
    assign bus.de           = de_q;
    assign bus.locked       = locked_q;
    assign bus.align_offset = offset_q;
    assign bus.lock_lost    = lock_lost_q;

endmodule
`default_nettype wire
